// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Two-requester arbiter and sequencer in front of the single-port program/data
// RAM. The RAM has a registered read with one cycle of latency. Port 0 is the
// CPU memory interface and port 1 is the loader/debug/IO master. The winner's
// access goes out on the RAM address, data, write-enable and read-enable lines.
// Read data is routed back to whichever port was granted.
//
// Each transaction goes IDLE -> ISSUE (-> RESP for reads) -> IDLE.
// A write takes 2 cycles and a read takes 3 cycles.
//
// Build option:
//   RAM_ARB_RR_EN  defined   : round-robin on simultaneous requests.
//                  undefined : fixed priority, where port 0 wins every tie.
//
// Ports:
//   clk                 system clock, all state on rising edge
//   clear_n             asynchronous active-low reset
//   req0/req1           access request, held until the matching gnt is seen
//   we0/we1             1 = write, 0 = read (stable while req high)
//   addr0/addr1         word address (stable while req high)
//   wdata0/wdata1       write data (stable while req high)
//   gnt0/gnt1           1-cycle pulse, request accepted
//   rvalid0/rvalid1     1-cycle pulse, rdata holds the read result
//   rdata               shared read data (combinational pass-through of ram_rdata)
//   busy                high whenever the sequencer is not idle
//   ram_addr/ram_wdata  RAM address and write data
//   ram_we/ram_re       RAM write and read strobes
//   ram_rdata           RAM read data
module ram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              busy_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              ram_we_q;
    logic              ram_re_q;
    logic              win_q;     // port that owns the transaction in flight

    logic              pick1_d;   // 1 = port 1 wins the current IDLE-cycle arbitration
    logic              we_sel_d;

`ifdef RAM_ARB_RR_EN
    logic              last_winner_q;

    // On a tie, the port that did not win last time gets the grant.
    // A lone request always wins.
    always_comb begin
        pick1_d = req1 & (~req0 | ~last_winner_q);
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not requesting.
    always_comb begin
        pick1_d = req1 & ~req0;
    end
`endif

    always_comb begin
        we_sel_d = pick1_d ? we1 : we0;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            busy_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            win_q       <= 1'b0;
`ifdef RAM_ARB_RR_EN
            // Port 0 wins the first contested round after reset.
            last_winner_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        ram_addr_q  <= pick1_d ? addr1 : addr0;
                        ram_wdata_q <= pick1_d ? wdata1 : wdata0;
                        ram_we_q    <= we_sel_d;
                        ram_re_q    <= ~we_sel_d;
                        gnt0_q      <= ~pick1_d;
                        gnt1_q      <= pick1_d;
                        win_q       <= pick1_d;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
`ifdef RAM_ARB_RR_EN
                        last_winner_q <= pick1_d;
`endif
                    end
                end
                ISSUE: begin
                    // The RAM samples its strobes at this edge.
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_re_q <= 1'b0;
                    if (ram_we_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rvalid0_q <= ~win_q;
                        rvalid1_q <= win_q;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    ram_we_q  <= 1'b0;
                    ram_re_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign busy      = busy_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    // The RAM output register already provides the timing.
    assign rdata     = ram_rdata;

endmodule
